// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type and address-width helper for the multiport register file
package regfile_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_read_mux.sv
// regfile_read_mux: NUM_REGS:1 combinational select of one register by address
module regfile_read_mux import regfile_pkg::*; #(
  parameter int N = 32,
  parameter int NUM_REGS = 16,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic [N-1:0]      mem [NUM_REGS],
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      data
);
  assign data = mem[addr];
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: NUM_REGS x N register file, NUM_RD read ports, one write port,
// sequential clear engine, optional bypass, registered read and hardwired zero register
module regfile_multiport import regfile_pkg::*; #(
  parameter int N = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD = 2,
  parameter bit WR_BYPASS = 1'b1,
  parameter bit REG_READ = 1'b0,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0][N-1:0]       rd_data_o,
  input  logic                           we_i,
  input  logic [ADDR_W-1:0]              wr_addr_i,
  input  logic [N-1:0]                   wr_data_i,
  input  logic                           clear_i,
  output logic                           busy_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  rf_state_t state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [N-1:0] mem [NUM_REGS];
  logic [NUM_RD-1:0][N-1:0] rd_comb;
  logic busy, wr_ok;
  assign busy = state == RF_CLEAR;
  assign busy_o = busy;
  assign wr_ok = !busy && we_i && !(ZERO_REG && wr_addr_i == '0);
  always_comb state_nx = busy ? (clr_cnt == LAST ? RF_IDLE : RF_CLEAR) : (clear_i ? RF_CLEAR : RF_IDLE);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= RF_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      clr_cnt <= (busy && clr_cnt != LAST) ? clr_cnt + ADDR_W'(1) : '0;
    end
  // No reset on the array so it maps onto RAM; the clear engine zeroes it instead
  always_ff @(posedge clk_i)
    if (busy) mem[clr_cnt] <= '0;
    else if (wr_ok) mem[wr_addr_i] <= wr_data_i;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [N-1:0] raw;
    regfile_read_mux #(.N(N), .NUM_REGS(NUM_REGS)) u_mux (
      .mem  (mem),
      .addr (rd_addr_i[k]),
      .data (raw)
    );
    assign rd_comb[k] = (ZERO_REG && rd_addr_i[k] == '0) ? '0 :
                        (WR_BYPASS && wr_ok && wr_addr_i == rd_addr_i[k]) ? wr_data_i : raw;
  end
  if (REG_READ) begin : g_reg
    always_ff @(posedge clk_i) rd_data_o <= rst_i ? '0 : rd_comb;
  end else begin : g_comb
    assign rd_data_o = rd_comb;
  end
endmodule
